// File: rtl/octree_pkg.sv
// rtl/octree_pkg.sv - shared opcodes, widths and command record for the Octree command path
package octree_pkg;

    localparam logic [2:0] OP_SEARCH = 3'b001;
    localparam logic [2:0] OP_UPDATE = 3'b010;

    localparam int POS_W   = 12;
    localparam int FEAT_W  = 64;
    localparam int COORD_W = 16;
    localparam int DIM     = 3;

    typedef struct packed {
        logic [2:0]                    ctrl;
        logic [POS_W-1:0]              pos_encode;
        logic [FEAT_W-1:0]             feature;
        logic [DIM-1:0][COORD_W-1:0]   cam_pos;
    } octree_cmd_t;

    function automatic logic is_legal_op(input logic [2:0] op);
        return (op == OP_SEARCH) || (op == OP_UPDATE);
    endfunction

endpackage

// File: rtl/octree_cmd_fifo.sv
// rtl/octree_cmd_fifo.sv - synchronous command FIFO with extra-MSB full/empty pointers
module octree_cmd_fifo
    import octree_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  octree_cmd_t push_data,
    input  logic        pop,
    output octree_cmd_t pop_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);

    octree_cmd_t   mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/octree_cmd_dispatch.sv
// rtl/octree_cmd_dispatch.sv - in-order command issue to Octree with search credit throttling and tagged results
module octree_cmd_dispatch
    import octree_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    parameter int TAG_W   = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          host_valid,
    output logic                          host_ready,
    input  logic [2:0]                    host_ctrl,
    input  logic [POS_W-1:0]              host_pos_encode,
    input  logic [FEAT_W-1:0]             host_feature,
    input  logic [DIM-1:0][COORD_W-1:0]   host_cam_pos,
    output logic                          oct_req_valid,
    input  logic                          oct_req_ready,
    output logic [2:0]                    oct_ctrl,
    output logic [POS_W-1:0]              oct_pos_encode,
    output logic [FEAT_W-1:0]             oct_feature,
    output logic [DIM-1:0][COORD_W-1:0]   oct_cam_pos,
    input  logic                          oct_rsp_valid,
    output logic                          oct_rsp_ready,
    input  logic [FEAT_W-1:0]             oct_rsp_feature,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [FEAT_W-1:0]             rsp_feature,
    output logic [TAG_W-1:0]              rsp_tag,
    output logic [3:0]                    outstanding,
    output logic                          err_illegal,
    output logic                          err_unexp
);

    octree_cmd_t    push_cmd;
    octree_cmd_t    head;
    logic           full;
    logic           empty;
    logic           accept;
    logic           push;
    logic           head_is_search;
    logic           issue;
    logic           search_issue;
    logic           rsp_accept;
    logic           good_rsp;
    logic           unexp_rsp;
    logic [TAG_W-1:0] rsp_cnt;

    assign push_cmd = '{ctrl: host_ctrl, pos_encode: host_pos_encode,
                        feature: host_feature, cam_pos: host_cam_pos};

    assign host_ready = !full;
    assign accept     = host_valid && host_ready;
    assign push       = accept && is_legal_op(host_ctrl);

    octree_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_cmd),
        .pop       (issue),
        .pop_data  (head),
        .full      (full),
        .empty     (empty)
    );

    // Only legal opcodes are queued, so a non-search head is always an update.
    assign head_is_search = (head.ctrl == OP_SEARCH);
    assign oct_req_valid  = !empty && (!head_is_search || (outstanding < 4'(MAX_OUT)));
    assign oct_ctrl       = head.ctrl;
    assign oct_pos_encode = head.pos_encode;
    assign oct_feature    = head.feature;
    assign oct_cam_pos    = head.cam_pos;

    assign issue        = oct_req_valid && oct_req_ready;
    assign search_issue = issue && head_is_search;

    assign oct_rsp_ready = !rsp_valid || rsp_ready;
    assign rsp_accept    = oct_rsp_valid && oct_rsp_ready;
    assign good_rsp      = rsp_accept && (outstanding != 4'd0);
    assign unexp_rsp     = rsp_accept && (outstanding == 4'd0);

    // Credit gating keeps the counter within 0..MAX_OUT, so it cannot wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= 4'd0;
        end else if (search_issue && !good_rsp) begin
            outstanding <= outstanding + 4'd1;
        end else if (good_rsp && !search_issue) begin
            outstanding <= outstanding - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid   <= 1'b0;
            rsp_feature <= '0;
            rsp_tag     <= '0;
            rsp_cnt     <= '0;
        end else if (good_rsp) begin
            rsp_valid   <= 1'b1;
            rsp_feature <= oct_rsp_feature;
            rsp_tag     <= rsp_cnt;
            rsp_cnt     <= rsp_cnt + 1'b1;
        end else if (rsp_ready) begin
            rsp_valid   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_illegal <= 1'b0;
            err_unexp   <= 1'b0;
        end else begin
            if (accept && !is_legal_op(host_ctrl)) begin
                err_illegal <= 1'b1;
            end
            if (unexp_rsp) begin
                err_unexp <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_octree_cmd_dispatch.sv
// tb/tb_octree_cmd_dispatch.sv - directed self-checking bench for octree_cmd_dispatch
module tb_octree_cmd_dispatch;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_valid;
    logic [2:0]  host_ctrl;
    logic [11:0] host_pos_encode;
    logic [63:0] host_feature;
    logic [2:0][15:0] host_cam_pos;
    logic        oct_req_ready;
    logic        oct_rsp_valid;
    logic [63:0] oct_rsp_feature;
    logic        rsp_ready;

    logic        a_host_ready, a_req_valid, a_rsp_ready, a_rsp_valid, a_err_illegal, a_err_unexp;
    logic [2:0]  a_ctrl;
    logic [11:0] a_pos;
    logic [63:0] a_feature, a_rsp_feature;
    logic [2:0][15:0] a_cam;
    logic [3:0]  a_tag, a_out;

    logic        b_host_ready, b_req_valid, b_rsp_ready, b_rsp_valid, b_err_illegal, b_err_unexp;
    logic [2:0]  b_ctrl;
    logic [11:0] b_pos;
    logic [63:0] b_feature, b_rsp_feature;
    logic [2:0][15:0] b_cam;
    logic [3:0]  b_tag, b_out;

    int n_checks = 0;
    int n_errs   = 0;
    int acc_cnt;
    int iss_cnt;

    always #5 clk = ~clk;

    octree_cmd_dispatch #(.DEPTH(4), .MAX_OUT(2), .TAG_W(4)) dut_a (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(a_host_ready), .host_ctrl(host_ctrl),
        .host_pos_encode(host_pos_encode), .host_feature(host_feature), .host_cam_pos(host_cam_pos),
        .oct_req_valid(a_req_valid), .oct_req_ready(oct_req_ready), .oct_ctrl(a_ctrl),
        .oct_pos_encode(a_pos), .oct_feature(a_feature), .oct_cam_pos(a_cam),
        .oct_rsp_valid(oct_rsp_valid), .oct_rsp_ready(a_rsp_ready), .oct_rsp_feature(oct_rsp_feature),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_feature(a_rsp_feature), .rsp_tag(a_tag),
        .outstanding(a_out), .err_illegal(a_err_illegal), .err_unexp(a_err_unexp)
    );

    octree_cmd_dispatch #(.DEPTH(4), .MAX_OUT(1), .TAG_W(4)) dut_b (
        .clk(clk), .rst(rst),
        .host_valid(host_valid), .host_ready(b_host_ready), .host_ctrl(host_ctrl),
        .host_pos_encode(host_pos_encode), .host_feature(host_feature), .host_cam_pos(host_cam_pos),
        .oct_req_valid(b_req_valid), .oct_req_ready(oct_req_ready), .oct_ctrl(b_ctrl),
        .oct_pos_encode(b_pos), .oct_feature(b_feature), .oct_cam_pos(b_cam),
        .oct_rsp_valid(oct_rsp_valid), .oct_rsp_ready(b_rsp_ready), .oct_rsp_feature(oct_rsp_feature),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_feature(b_rsp_feature), .rsp_tag(b_tag),
        .outstanding(b_out), .err_illegal(b_err_illegal), .err_unexp(b_err_unexp)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next;
        @(posedge clk);
        #1;
    endtask

    task automatic host_cmd(input logic [2:0] ctrl, input logic [11:0] pos);
        host_valid      = 1'b1;
        host_ctrl       = ctrl;
        host_pos_encode = pos;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        host_valid = 1'b0; host_ctrl = 3'b000; host_pos_encode = '0; host_feature = '0;
        host_cam_pos = '0; oct_req_ready = 1'b0; oct_rsp_valid = 1'b0; oct_rsp_feature = '0;
        rsp_ready = 1'b1;
        next;
        next;
        rst = 1'b0;
    endtask

    initial begin
        // reset state
        do_reset;
        #1;
        check("rst_host_ready", a_host_ready, 1);
        check("rst_req_valid", a_req_valid, 0);
        check("rst_outstanding", a_out, 0);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_rsp_feature", a_rsp_feature, 0);
        check("rst_rsp_tag", a_tag, 0);
        check("rst_errs", {a_err_illegal, a_err_unexp}, 0);

        // single update
        oct_req_ready = 1'b1;
        host_cmd(3'b010, 12'd1);
        host_feature = 64'hA5A5_A5A5_A5A5_A5A5;
        #1;
        check("upd_no_bypass", a_req_valid, 0);
        next;
        host_valid = 1'b0;
        #1;
        check("upd_req_valid", a_req_valid, 1);
        check("upd_ctrl", a_ctrl, 3'b010);
        check("upd_pos", a_pos, 12'd1);
        check("upd_feature", a_feature, 64'hA5A5_A5A5_A5A5_A5A5);
        next;
        #1;
        check("upd_popped", a_req_valid, 0);
        check("upd_outstanding", a_out, 0);
        check("upd_no_rsp", a_rsp_valid, 0);

        // single search with response three cycles after issue
        host_cmd(3'b001, 12'd7);
        host_cam_pos = {16'd30, 16'd20, 16'd10};
        next;
        host_valid = 1'b0;
        #1;
        check("srch_req_valid", a_req_valid, 1);
        check("srch_cam", a_cam, 48'h001E_0014_000A);
        check("srch_out0", a_out, 0);
        next;
        #1;
        check("srch_out1", a_out, 1);
        check("srch_req_done", a_req_valid, 0);
        next;
        next;
        oct_rsp_valid = 1'b1; oct_rsp_feature = 64'h1234;
        #1;
        check("srch_rsp_ready", a_rsp_ready, 1);
        check("srch_no_early_rsp", a_rsp_valid, 0);
        next;
        oct_rsp_valid = 1'b0;
        #1;
        check("srch_rsp_valid", a_rsp_valid, 1);
        check("srch_rsp_feature", a_rsp_feature, 64'h1234);
        check("srch_rsp_tag", a_tag, 0);
        check("srch_out_back0", a_out, 0);
        next;
        #1;
        check("srch_rsp_drained", a_rsp_valid, 0);

        // credit limit: searches stall at MAX_OUT=2, FIFO fills
        do_reset;
        oct_req_ready = 1'b1;
        acc_cnt = 0; iss_cnt = 0;
        host_cmd(3'b001, 12'd0);
        for (int i = 0; i < 8; i++) begin
            host_pos_encode = 12'(i);
            #1;
            if (host_valid && a_host_ready) acc_cnt++;
            if (a_req_valid && oct_req_ready) iss_cnt++;
            next;
        end
        host_valid = 1'b0;
        #1;
        check("credit_accepted", acc_cnt, 6);
        check("credit_issued", iss_cnt, 2);
        check("credit_outstanding", a_out, 2);
        check("credit_req_blocked", a_req_valid, 0);
        check("credit_full", a_host_ready, 0);
        oct_rsp_valid = 1'b1; oct_rsp_feature = 64'h55;
        next;
        oct_rsp_valid = 1'b0;
        #1;
        check("credit_freed_out", a_out, 1);
        check("credit_freed_valid", a_req_valid, 1);
        check("credit_still_full", a_host_ready, 0);
        next;
        #1;
        check("credit_reissue_out", a_out, 2);
        check("credit_not_full", a_host_ready, 1);

        // strict order with MAX_OUT=1: search, update, search
        do_reset;
        oct_req_ready = 1'b0;
        host_cmd(3'b001, 12'd1);
        next;
        host_cmd(3'b010, 12'd2);
        #1;
        check("mix_head_first", b_pos, 12'd1);
        next;
        host_cmd(3'b001, 12'd3);
        next;
        host_valid = 1'b0;
        oct_req_ready = 1'b1;
        #1;
        check("mix_s1_valid", b_req_valid, 1);
        check("mix_s1_pos", b_pos, 12'd1);
        next;
        #1;
        check("mix_upd_valid", b_req_valid, 1);
        check("mix_upd_ctrl", b_ctrl, 3'b010);
        check("mix_upd_pos", b_pos, 12'd2);
        check("mix_out1", b_out, 1);
        next;
        #1;
        check("mix_s2_blocked", b_req_valid, 0);
        next;
        oct_rsp_valid = 1'b1; oct_rsp_feature = 64'hAAAA;
        #1;
        check("mix_s2_still_blocked", b_req_valid, 0);
        next;
        oct_rsp_valid = 1'b0;
        #1;
        check("mix_rsp0_valid", b_rsp_valid, 1);
        check("mix_rsp0_tag", b_tag, 0);
        check("mix_rsp0_feature", b_rsp_feature, 64'hAAAA);
        check("mix_s2_valid", b_req_valid, 1);
        check("mix_s2_pos", b_pos, 12'd3);
        next;
        #1;
        check("mix_s2_out", b_out, 1);
        next;
        oct_rsp_valid = 1'b1; oct_rsp_feature = 64'hBBBB;
        next;
        oct_rsp_valid = 1'b0;
        #1;
        check("mix_rsp1_tag", b_tag, 1);
        check("mix_rsp1_feature", b_rsp_feature, 64'hBBBB);
        check("mix_out_end", b_out, 0);

        // illegal opcode and unexpected response
        do_reset;
        oct_req_ready = 1'b1;
        host_cmd(3'b111, 12'd9);
        #1;
        check("ill_host_ready", a_host_ready, 1);
        next;
        host_valid = 1'b0;
        #1;
        check("ill_err_set", a_err_illegal, 1);
        check("ill_not_queued", a_req_valid, 0);
        next;
        next;
        #1;
        check("ill_err_sticky", a_err_illegal, 1);
        check("ill_never_issued", a_req_valid, 0);
        oct_rsp_valid = 1'b1; oct_rsp_feature = 64'hDEAD;
        #1;
        check("unexp_rsp_ready", a_rsp_ready, 1);
        next;
        oct_rsp_valid = 1'b0;
        #1;
        check("unexp_err_set", a_err_unexp, 1);
        check("unexp_no_rsp", a_rsp_valid, 0);
        check("unexp_out", a_out, 0);
        next;
        #1;
        check("unexp_err_sticky", a_err_unexp, 1);

        // reset mid-operation
        do_reset;
        oct_req_ready = 1'b1;
        rsp_ready = 1'b0;
        host_cmd(3'b001, 12'd1);
        next;
        host_valid = 1'b0;
        next;
        oct_rsp_valid = 1'b1; oct_rsp_feature = 64'h77;
        next;
        oct_rsp_valid = 1'b0;
        host_cmd(3'b001, 12'd2);
        next;
        host_cmd(3'b000, 12'd0);
        next;
        oct_req_ready = 1'b0;
        host_cmd(3'b001, 12'd3);
        next;
        host_cmd(3'b001, 12'd4);
        next;
        host_valid = 1'b0;
        #1;
        check("mid_pre_out", a_out, 1);
        check("mid_pre_rsp", a_rsp_valid, 1);
        check("mid_pre_queued", a_req_valid, 1);
        check("mid_pre_err", a_err_illegal, 1);
        rst = 1'b1;
        next;
        rst = 1'b0;
        #1;
        check("mid_empty", a_req_valid, 0);
        check("mid_out", a_out, 0);
        check("mid_rsp_valid", a_rsp_valid, 0);
        check("mid_rsp_feature", a_rsp_feature, 0);
        check("mid_errs", {a_err_illegal, a_err_unexp}, 0);
        check("mid_host_ready", a_host_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
